// File: rtl/life_grid_engine.sv
// Conway life engine: one grid row per cycle into a shadow grid, committed atomically; step to done is ROWS+1 cycles.
// No queueing: step and load_en are dropped while busy; the display always shows the last committed generation.
module life_grid_engine #(
  parameter int COLS  = 16,
  parameter int ROWS  = 16,
  parameter int WRAP  = 1,
  parameter int GEN_W = 16
) (
  input  logic                               dclk,
  input  logic                               clr,
  input  logic                               load_en,
  input  logic [$clog2(ROWS)-1:0]            load_row,
  input  logic [COLS-1:0]                    load_data,
  input  logic                               step,
  output logic                               busy,
  output logic                               done,
  output logic [GEN_W-1:0]                   gen_count,
  output logic [$clog2(ROWS*COLS+1)-1:0]     live_count,
  input  logic [$clog2(ROWS)-1:0]            rd_row,
  output logic [COLS-1:0]                    rd_data
);

  localparam int RW = $clog2(ROWS);
  localparam int LW = $clog2(ROWS*COLS+1);

  typedef enum logic [1:0] {IDLE, COMPUTE, COMMIT} state_t;

  state_t          state, state_nxt;
  logic [COLS-1:0] cur [ROWS];
  logic [COLS-1:0] nxt [ROWS];
  logic [RW-1:0]   r;
  logic [LW-1:0]   sum;
  logic [COLS-1:0] row_up, row_dn, row_new;
  logic            accept, last_row, load_ok, rd_ok;

  function automatic logic [COLS-1:0] life_row(input logic [COLS-1:0] up,
                                               input logic [COLS-1:0] mid,
                                               input logic [COLS-1:0] dn);
    logic [COLS-1:0] res;
    logic [3:0]      n;
    logic            lv, rv;
    int              lc, rc;
    res = '0;
    for (int c = 0; c < COLS; c++) begin
      lc = (c == 0) ? COLS - 1 : c - 1;
      rc = (c == COLS - 1) ? 0 : c + 1;
      // Edge columns only see their wrapped partner on a torus.
      lv = (WRAP != 0) || (c != 0);
      rv = (WRAP != 0) || (c != COLS - 1);
      n = {3'b000, up[c]} + {3'b000, dn[c]}
        + {3'b000, up[lc] & lv} + {3'b000, mid[lc] & lv} + {3'b000, dn[lc] & lv}
        + {3'b000, up[rc] & rv} + {3'b000, mid[rc] & rv} + {3'b000, dn[rc] & rv};
      res[c] = (n == 4'd3) || (mid[c] && (n == 4'd2));
    end
    return res;
  endfunction

  function automatic logic [LW-1:0] popcount(input logic [COLS-1:0] v);
    logic [LW-1:0] cnt;
    cnt = '0;
    for (int c = 0; c < COLS; c++) cnt = cnt + {{(LW-1){1'b0}}, v[c]};
    return cnt;
  endfunction

  assign load_ok  = 32'(load_row) < ROWS;
  assign rd_ok    = 32'(rd_row) < ROWS;
  assign last_row = (r == RW'(ROWS - 1));
  assign accept   = (state == IDLE) && step && !load_en;

  always_comb begin
    row_up  = (r == '0) ? ((WRAP != 0) ? cur[ROWS-1] : '0) : cur[r - RW'(1)];
    row_dn  = last_row  ? ((WRAP != 0) ? cur[0] : '0)      : cur[r + RW'(1)];
    row_new = life_row(row_up, cur[r], row_dn);
  end

  always_ff @(posedge dclk) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    case (state)
      IDLE:    if (accept) state_nxt = COMPUTE;
      COMPUTE: begin
        busy = 1'b1;
        if (last_row) state_nxt = COMMIT;
      end
      COMMIT:  begin
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge dclk) begin
    if (clr) begin
      for (int i = 0; i < ROWS; i++) begin
        cur[i] <= '0;
        nxt[i] <= '0;
      end
      r          <= '0;
      sum        <= '0;
      done       <= 1'b0;
      gen_count  <= '0;
      live_count <= '0;
      rd_data    <= '0;
    end else begin
      done    <= 1'b0;
      rd_data <= rd_ok ? cur[rd_row] : '0;
      case (state)
        IDLE: begin
          if (load_en && load_ok) cur[load_row] <= load_data;
          if (accept) begin
            r   <= '0;
            sum <= '0;
          end
        end
        COMPUTE: begin
          nxt[r] <= row_new;
          sum    <= sum + popcount(row_new);
          r      <= last_row ? '0 : r + RW'(1);
        end
        COMMIT: begin
          for (int i = 0; i < ROWS; i++) cur[i] <= nxt[i];
          live_count <= sum;
          gen_count  <= gen_count + GEN_W'(1);
          done       <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
